ysyx_22040125_lsu: RTL and testbench

Load/store initiator between the CPU MEM stage and the 64-bit data memory responder. It accepts one load or store per handshake and drives a doubleword-aligned memory request with a byte write mask and lane-shifted write data. For loads, it extracts the addressed byte, half, word or doubleword lane from the returned data and sign- or zero-extends it. It asserts stall_mem while a transaction is outstanding and reports timeout and misalignment errors.

---
 rtl/ysyx_22040125_lsu_if.sv | 44 ++++
 rtl/ysyx_22040125_lsu.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22040125_lsu.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040125_lsu_if.sv
// Bus interfaces for the load/store unit: CPU-side request/response and
// memory-side request/response. Master drives the request, slave answers.
interface ysyx_22040125_lsu_cpu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        stall_mem;

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err, stall_mem
    );
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err, stall_mem
    );
endinterface

interface ysyx_22040125_lsu_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );
    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit between the MEM stage and a 64-bit data memory.
// Optional macro YSYX_LSU_MISALIGN_TRAP_EN: misaligned accesses complete
// immediately with resp_err instead of being silently size-aligned.
module ysyx_22040125_lsu #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22040125_lsu_cpu_if.slave         cpu,
    ysyx_22040125_lsu_mem_if.master        mem
);
    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    state_t            r_state,         w_nxt_state;
    logic              r_mem_req_valid, w_nxt_mem_req_valid;
    logic [31:0]       r_mem_addr,      w_nxt_mem_addr;
    logic              r_mem_wen,       w_nxt_mem_wen;
    logic [7:0]        r_mem_wmask,     w_nxt_mem_wmask;
    logic [63:0]       r_mem_wdata,     w_nxt_mem_wdata;
    logic              r_resp_valid,    w_nxt_resp_valid;
    logic [63:0]       r_resp_data,     w_nxt_resp_data;
    logic              r_resp_err,      w_nxt_resp_err;
    logic [CNT_W-1:0]  r_cnt,           w_nxt_cnt;
    logic [1:0]        r_size,          w_nxt_size;
    logic              r_unsigned,      w_nxt_unsigned;
    logic [2:0]        r_off,           w_nxt_off;

    logic [2:0]        w_off;
    logic [7:0]        w_mask;
    logic [63:0]       w_wdata;
    logic [63:0]       w_lane;
    logic [63:0]       w_load;

    // Size-aligned lane offset and byte mask of the incoming request
    always_comb begin
        w_off  = cpu.req_addr[2:0];
        w_mask = 8'hFF;
        unique case (cpu.req_size)
            2'd0: begin w_off = cpu.req_addr[2:0];          w_mask = 8'h01 << cpu.req_addr[2:0];          end
            2'd1: begin w_off = {cpu.req_addr[2:1], 1'b0};  w_mask = 8'h03 << {cpu.req_addr[2:1], 1'b0};  end
            2'd2: begin w_off = {cpu.req_addr[2], 2'b00};   w_mask = 8'h0F << {cpu.req_addr[2], 2'b00};   end
            2'd3: begin w_off = 3'b000;                     w_mask = 8'hFF;                               end
        endcase
    end

    assign w_wdata = cpu.req_wdata << {w_off, 3'b000};

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    // Misaligned exactly when alignment would have moved the offset
    assign w_misalign = (w_off != cpu.req_addr[2:0]);
`endif

    // Select the addressed lane of the read doubleword and extend it
    always_comb begin
        w_lane = mem.mem_rdata >> {r_off, 3'b000};
        w_load = w_lane;
        unique case (r_size)
            2'd0: w_load = {{56{w_lane[7]  & ~r_unsigned}}, w_lane[7:0]};
            2'd1: w_load = {{48{w_lane[15] & ~r_unsigned}}, w_lane[15:0]};
            2'd2: w_load = {{32{w_lane[31] & ~r_unsigned}}, w_lane[31:0]};
            2'd3: w_load = w_lane;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_nxt_state         = r_state;
        w_nxt_mem_req_valid = r_mem_req_valid;
        w_nxt_mem_addr      = r_mem_addr;
        w_nxt_mem_wen       = r_mem_wen;
        w_nxt_mem_wmask     = r_mem_wmask;
        w_nxt_mem_wdata     = r_mem_wdata;
        w_nxt_resp_valid    = r_resp_valid;
        w_nxt_resp_data     = r_resp_data;
        w_nxt_resp_err      = r_resp_err;
        w_nxt_cnt           = r_cnt;
        w_nxt_size          = r_size;
        w_nxt_unsigned      = r_unsigned;
        w_nxt_off           = r_off;

        unique case (r_state)
            S_IDLE: begin
                if (cpu.req_valid) begin
                    w_nxt_size      = cpu.req_size;
                    w_nxt_unsigned  = cpu.req_unsigned;
                    w_nxt_off       = w_off;
                    w_nxt_mem_addr  = {cpu.req_addr[31:3], 3'b000};
                    w_nxt_mem_wen   = cpu.req_store;
                    w_nxt_mem_wmask = w_mask;
                    w_nxt_mem_wdata = w_wdata;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        w_nxt_state      = S_DONE;
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_resp_err   = 1'b1;
                        w_nxt_resp_data  = 64'h0;
                    end else begin
                        w_nxt_state         = S_REQ;
                        w_nxt_mem_req_valid = 1'b1;
                    end
`else
                    w_nxt_state         = S_REQ;
                    w_nxt_mem_req_valid = 1'b1;
`endif
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    w_nxt_state         = S_WAIT;
                    w_nxt_mem_req_valid = 1'b0;
                    w_nxt_cnt           = '0;
                end
            end
            S_WAIT: begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
                // A response in the timeout cycle still wins
                if (mem.mem_rsp_valid) begin
                    w_nxt_state      = S_DONE;
                    w_nxt_resp_valid = 1'b1;
                    w_nxt_resp_err   = 1'b0;
                    w_nxt_resp_data  = r_mem_wen ? 64'h0 : w_load;
                end else if ((TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST)) begin
                    w_nxt_state      = S_DONE;
                    w_nxt_resp_valid = 1'b1;
                    w_nxt_resp_err   = 1'b1;
                    w_nxt_resp_data  = 64'h0;
                end
            end
            S_DONE: begin
                w_nxt_state      = S_IDLE;
                w_nxt_resp_valid = 1'b0;
                w_nxt_resp_err   = 1'b0;
                w_nxt_resp_data  = 64'h0;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= 32'h0;
            r_mem_wen       <= 1'b0;
            r_mem_wmask     <= 8'h0;
            r_mem_wdata     <= 64'h0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= 64'h0;
            r_resp_err      <= 1'b0;
            r_cnt           <= '0;
            r_size          <= 2'd0;
            r_unsigned      <= 1'b0;
            r_off           <= 3'd0;
        end else begin
            r_state         <= w_nxt_state;
            r_mem_req_valid <= w_nxt_mem_req_valid;
            r_mem_addr      <= w_nxt_mem_addr;
            r_mem_wen       <= w_nxt_mem_wen;
            r_mem_wmask     <= w_nxt_mem_wmask;
            r_mem_wdata     <= w_nxt_mem_wdata;
            r_resp_valid    <= w_nxt_resp_valid;
            r_resp_data     <= w_nxt_resp_data;
            r_resp_err      <= w_nxt_resp_err;
            r_cnt           <= w_nxt_cnt;
            r_size          <= w_nxt_size;
            r_unsigned      <= w_nxt_unsigned;
            r_off           <= w_nxt_off;
        end
    end

    assign cpu.req_ready     = (r_state == S_IDLE) & ~rst;
    assign cpu.stall_mem     = (r_state != S_IDLE);
    assign cpu.resp_valid    = r_resp_valid;
    assign cpu.resp_data     = r_resp_data;
    assign cpu.resp_err      = r_resp_err;
    assign mem.mem_req_valid = r_mem_req_valid;
    assign mem.mem_addr      = r_mem_addr;
    assign mem.mem_wen       = r_mem_wen;
    assign mem.mem_wmask     = r_mem_wmask;
    assign mem.mem_wdata     = r_mem_wdata;
endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Self-checking bench for ysyx_22040125_lsu (timeout set to 4 cycles).
module tb_ysyx_22040125_lsu;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_22040125_lsu_cpu_if cpu();
    ysyx_22040125_lsu_mem_if mem();

    ysyx_22040125_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu),
        .mem (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access with a responding memory. rdly = cycles mem_req_ready
    // is held low; d = WAIT cycles before the response (d >= 4 -> timeout).
    task automatic do_access(input bit st, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [63:0] wd,
                             input int rdly, input int d, input logic [63:0] rd,
                             output logic [63:0] o_data, output bit o_err,
                             output logic [7:0] o_mask, output logic [63:0] o_wdata);
        int nb; int off; int nw; bit trap; bit tmo;
        logic [63:0]  e_data;
        logic [7:0]   e_mask;
        logic [63:0]  e_wdata;
        logic [105:0] e_mem;
        nb   = 1 << sz;
        off  = (int'(addr[2:0]) / nb) * nb;
        trap = 1'b0;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        trap = (int'(addr[2:0]) % nb) != 0;
`endif
        e_mask = 8'h0;
        for (int i = 0; i < nb; i++) e_mask[off + i] = 1'b1;
        e_wdata = wd << (8 * off);
        tmo     = (d >= 4);
        e_data  = 64'h0;
        if (!st && !tmo) begin
            for (int i = 0; i < nb; i++) e_data[8*i +: 8] = rd[8*(off+i) +: 8];
            if (!uns && nb < 8 && e_data[8*nb-1])
                for (int i = nb; i < 8; i++) e_data[8*i +: 8] = 8'hFF;
        end
        e_mem = {1'b1, addr[31:3], 3'b000, st, e_mask, e_wdata};

        checks++;
        if (cpu.req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: got %b expected 1", cpu.req_ready);
        end
        cpu.req_valid = 1'b1; cpu.req_store = st; cpu.req_size = sz;
        cpu.req_unsigned = uns; cpu.req_addr = addr; cpu.req_wdata = wd;
        tick();
        cpu.req_valid = 1'b0; cpu.req_store = 1'($urandom_range(1));
        cpu.req_size = 2'($urandom_range(3)); cpu.req_unsigned = 1'($urandom_range(1));
        cpu.req_addr = $urandom; cpu.req_wdata = {$urandom, $urandom};
        o_mask  = mem.mem_wmask;
        o_wdata = mem.mem_wdata;

        if (trap) begin
            checks++;
            if ({mem.mem_req_valid, cpu.resp_valid, cpu.resp_err, cpu.resp_data} !== {3'b011, 64'h0}) begin
                errors++; $display("FAIL trap_resp: got v=%b rv=%b err=%b data=%h expected v=0 rv=1 err=1 data=0",
                                   mem.mem_req_valid, cpu.resp_valid, cpu.resp_err, cpu.resp_data);
            end
            o_data = cpu.resp_data; o_err = cpu.resp_err;
            tick();
            checks++;
            if ({cpu.resp_valid, cpu.req_ready, mem.mem_req_valid} !== 3'b010) begin
                errors++; $display("FAIL trap_idle: got rv=%b rdy=%b mv=%b expected 0 1 0",
                                   cpu.resp_valid, cpu.req_ready, mem.mem_req_valid);
            end
            return;
        end

        for (int k = 0; k <= rdly; k++) begin
            checks++;
            if ({mem.mem_req_valid, mem.mem_addr, mem.mem_wen, mem.mem_wmask, mem.mem_wdata} !== e_mem ||
                cpu.stall_mem !== 1'b1 || cpu.resp_valid !== 1'b0) begin
                errors++; $display("FAIL req_hold[%0d]: got %h st=%b rv=%b expected %h st=1 rv=0", k,
                    {mem.mem_req_valid, mem.mem_addr, mem.mem_wen, mem.mem_wmask, mem.mem_wdata},
                    cpu.stall_mem, cpu.resp_valid, e_mem);
            end
            mem.mem_req_ready = (k == rdly);
            mem.mem_rsp_valid = 1'($urandom_range(1));
            mem.mem_rdata     = {$urandom, $urandom};
            tick();
        end
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;

        nw = tmo ? 3 : d;
        for (int k = 0; k < nw; k++) begin
            checks++;
            if ({mem.mem_req_valid, cpu.resp_valid, cpu.stall_mem} !== 3'b001) begin
                errors++; $display("FAIL wait[%0d]: got mv=%b rv=%b st=%b expected 0 0 1", k,
                                   mem.mem_req_valid, cpu.resp_valid, cpu.stall_mem);
            end
            tick();
        end
        mem.mem_rsp_valid = !tmo;
        mem.mem_rdata     = tmo ? {$urandom, $urandom} : rd;
        tick();
        mem.mem_rsp_valid = 1'b0;
        mem.mem_rdata     = {$urandom, $urandom};

        checks++;
        if ({cpu.resp_valid, cpu.resp_err, cpu.resp_data, cpu.req_ready, cpu.stall_mem} !== {1'b1, tmo, e_data, 2'b01}) begin
            errors++; $display("FAIL done: got rv=%b err=%b data=%h rdy=%b st=%b expected rv=1 err=%b data=%h rdy=0 st=1",
                               cpu.resp_valid, cpu.resp_err, cpu.resp_data, cpu.req_ready, cpu.stall_mem, tmo, e_data);
        end
        o_data = cpu.resp_data; o_err = cpu.resp_err;
        tick();
        checks++;
        if ({cpu.resp_valid, cpu.req_ready, cpu.stall_mem} !== 3'b010) begin
            errors++; $display("FAIL post_done: got rv=%b rdy=%b st=%b expected 0 1 0",
                               cpu.resp_valid, cpu.req_ready, cpu.stall_mem);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({mem.mem_req_valid, mem.mem_wen, mem.mem_wmask, mem.mem_wdata, mem.mem_addr,
             cpu.resp_valid, cpu.resp_data, cpu.resp_err, cpu.stall_mem, cpu.req_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs: got mv=%b wen=%b mask=%h wd=%h addr=%h rv=%b rd=%h err=%b st=%b rdy=%b expected all 0",
                mem.mem_req_valid, mem.mem_wen, mem.mem_wmask, mem.mem_wdata, mem.mem_addr,
                cpu.resp_valid, cpu.resp_data, cpu.resp_err, cpu.stall_mem, cpu.req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cpu.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", cpu.req_ready);
        end
    endtask

    task automatic test_store_byte();
        logic [63:0] data, wdo; bit err; logic [7:0] mask;
        do_access(1'b1, 2'd0, 1'b0, 32'h8000_0003, 64'h5A, 0, 0, 64'h0, data, err, mask, wdo);
        checks++;
        if ({mask, wdo[31:24], data, err} !== {8'h08, 8'h5A, 64'h0, 1'b0}) begin
            errors++; $display("FAIL store_byte: got mask=%h lane=%h data=%h err=%b expected 08 5a 0 0",
                               mask, wdo[31:24], data, err);
        end
    endtask

    task automatic test_load_half();
        logic [63:0] data, wdo; bit err; logic [7:0] mask;
        do_access(1'b0, 2'd1, 1'b0, 32'h8000_0006, 64'h0, 0, 0, 64'h8123_0000_0000_0000, data, err, mask, wdo);
        checks++;
        if (data !== 64'hFFFF_FFFF_FFFF_8123) begin
            errors++; $display("FAIL load_half_signed: got %h expected ffffffffffff8123", data);
        end
        do_access(1'b0, 2'd1, 1'b1, 32'h8000_0006, 64'h0, 1, 1, 64'h8123_0000_0000_0000, data, err, mask, wdo);
        checks++;
        if (data !== 64'h0000_0000_0000_8123) begin
            errors++; $display("FAIL load_half_unsigned: got %h expected 0000000000008123", data);
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] data, wdo, rd; bit err; logic [7:0] mask;
        rd = {1'b1, 31'($urandom), $urandom};
        do_access(1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'h0, 5, 2, rd, data, err, mask, wdo);
        checks++;
        if (data !== {{32{rd[63]}}, rd[63:32]}) begin
            errors++; $display("FAIL load_word_wait: got %h expected %h", data, {{32{rd[63]}}, rd[63:32]});
        end
    endtask

    task automatic test_timeout();
        logic [63:0] data, wdo; bit err; logic [7:0] mask;
        do_access(1'b0, 2'd3, 1'b0, 32'h8000_0010, 64'h0, 2, 4, 64'h0, data, err, mask, wdo);
        checks++;
        if ({err, data} !== {1'b1, 64'h0}) begin
            errors++; $display("FAIL timeout: got err=%b data=%h expected err=1 data=0", err, data);
        end
    endtask

    task automatic test_reset_mid();
        cpu.req_valid = 1'b1; cpu.req_store = 1'b0; cpu.req_size = 2'd3;
        cpu.req_unsigned = 1'b0; cpu.req_addr = 32'h8000_0040; cpu.req_wdata = 64'h0;
        tick();
        cpu.req_valid = 1'b0; mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({cpu.resp_valid, cpu.stall_mem, cpu.req_ready, mem.mem_req_valid, mem.mem_addr, mem.mem_wmask} !== '0) begin
            errors++; $display("FAIL reset_mid: got rv=%b st=%b rdy=%b mv=%b addr=%h mask=%h expected all 0",
                cpu.resp_valid, cpu.stall_mem, cpu.req_ready, mem.mem_req_valid, mem.mem_addr, mem.mem_wmask);
        end
        rst = 1'b0; mem.mem_rsp_valid = 1'b1; mem.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        mem.mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({cpu.resp_valid, cpu.resp_data, cpu.stall_mem, cpu.req_ready} !== {66'h0, 1'b1}) begin
                errors++; $display("FAIL late_rsp[%0d]: got rv=%b data=%h st=%b rdy=%b expected 0 0 0 1", k,
                                   cpu.resp_valid, cpu.resp_data, cpu.stall_mem, cpu.req_ready);
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        logic [63:0] data, wdo; bit err; logic [7:0] mask;
        do_access(1'b0, 2'd2, 1'b1, 32'h8000_0002, 64'h0, 0, 0, 64'h1122_3344_5566_7788, data, err, mask, wdo);
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        checks++;
        if ({err, data} !== {1'b1, 64'h0}) begin
            errors++; $display("FAIL misalign_trap: got err=%b data=%h expected 1 0", err, data);
        end
`else
        checks++;
        if ({mask, err, data} !== {8'h0F, 1'b0, 64'h0000_0000_5566_7788}) begin
            errors++; $display("FAIL misalign_forced: got mask=%h err=%b data=%h expected 0f 0 0000000055667788",
                               mask, err, data);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [63:0] data, wdo; bit err; logic [7:0] mask;
        for (int i = 0; i < 4; i++)
            do_access(1'(i % 2), 2'(i), 1'b0, 32'h8000_0100 + 32'(8 * i), {$urandom, $urandom},
                      0, 0, {$urandom, $urandom}, data, err, mask, wdo);
    endtask

    task automatic test_random();
        logic [63:0] data, wdo; bit err; logic [7:0] mask;
        int d;
        for (int i = 0; i < 40; i++) begin
            d = ($urandom_range(7) == 0) ? 4 : int'($urandom_range(3));
            do_access(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                      {4'h8, 28'($urandom)}, {$urandom, $urandom}, int'($urandom_range(3)), d,
                      {$urandom, $urandom}, data, err, mask, wdo);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        cpu.req_valid = 1'b0; cpu.req_store = 1'b0; cpu.req_size = 2'd0;
        cpu.req_unsigned = 1'b0; cpu.req_addr = 32'h0; cpu.req_wdata = 64'h0;
        mem.mem_req_ready = 1'b0; mem.mem_rsp_valid = 1'b0; mem.mem_rdata = 64'h0;
        test_reset();
        test_store_byte();
        test_load_half();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
